// File: rtl/ppi_pkg.sv
// Register map, control/status bit positions and mode/direction enums for the PPI handshake port.
package ppi_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CTRL = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_RSVD = 2'd3;

  localparam int CTRL_MODE = 0;
  localparam int CTRL_DIR  = 1;
  localparam int CTRL_INTE = 2;
  localparam logic [2:0] CTRL_RESET = 3'b010;

  localparam int STAT_INTR  = 0;
  localparam int STAT_EMPTY = 1;
  localparam int STAT_FULL  = 2;
  localparam int STAT_OVF   = 3;
  localparam int STAT_CNT   = 4;

  typedef enum logic {MODE_BASIC = 1'b0, MODE_STROBED = 1'b1} mode_e;
  typedef enum logic {DIR_OUT = 1'b0, DIR_IN = 1'b1} dir_e;

endpackage

// File: rtl/ppi_fifo.sv
// Handshake FIFO: head visible combinationally, push/pop take effect on the clock edge.
// Pop is applied before push, so a full FIFO accepts a push in the same cycle as a pop.
module ppi_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush) mem[wptr] <= din;
  end

endmodule

// File: rtl/ppi_hs_port.sv
// CPU-facing parallel port with basic and strobed handshake modes; DOUT and INTR are registered.
// Peripheral strobes/acks act on the 3rd CLK edge after the pin falls; overflowing pushes are dropped and flagged.
module ppi_hs_port
  import ppi_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CS,
  input  logic             RD,
  input  logic             WR,
  input  logic [1:0]       ADDR,
  input  logic [WIDTH-1:0] DIN,
  output logic [WIDTH-1:0] DOUT,
  input  logic [WIDTH-1:0] PORT_IN,
  output logic [WIDTH-1:0] PORT_OUT,
  output logic             PORT_OE,
  input  logic             STB_N,
  input  logic             ACK_N,
  output logic             IBF,
  output logic             OBF_N,
  output logic             INTR
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [2:0]       ctrl;
  mode_e            mode;
  dir_e             dir;
  logic             inte;
  logic             ovf;
  logic [WIDTH-1:0] latch, rdata, in_head, out_head;
  logic [2:0]       stb_sync, ack_sync;
  logic             stb_evt, ack_evt;
  logic             rd_cyc, wr_cyc, data_rd, data_wr, ctrl_wr, stat_rd;
  logic             strobed_in, strobed_out;
  logic             in_push, in_pop, in_full, in_empty;
  logic             out_push, out_pop, out_full, out_empty;
  logic [CW-1:0]    in_cnt, out_cnt, sel_cnt;
  logic             sel_full, sel_empty;
  logic             ovf_set, intr_next;
  logic [8:0]       stat;

  assign mode = mode_e'(ctrl[CTRL_MODE]);
  assign dir  = dir_e'(ctrl[CTRL_DIR]);
  assign inte = ctrl[CTRL_INTE];

  // sync[0], sync[1] form the synchronizer; sync[2] is the delayed copy for edge detection
  assign stb_evt = stb_sync[2] & ~stb_sync[1];
  assign ack_evt = ack_sync[2] & ~ack_sync[1];

  assign rd_cyc  = CS && RD && !WR;
  assign wr_cyc  = CS && WR && !RD;
  assign data_rd = rd_cyc && (ADDR == ADDR_DATA);
  assign stat_rd = rd_cyc && (ADDR == ADDR_STAT);
  assign data_wr = wr_cyc && (ADDR == ADDR_DATA);
  assign ctrl_wr = wr_cyc && (ADDR == ADDR_CTRL);

  assign strobed_in  = (mode == MODE_STROBED) && (dir == DIR_IN);
  assign strobed_out = (mode == MODE_STROBED) && (dir == DIR_OUT);
  assign in_push     = strobed_in && stb_evt;
  assign in_pop      = strobed_in && data_rd;
  assign out_push    = strobed_out && data_wr;
  assign out_pop     = strobed_out && ack_evt;

  assign ovf_set   = (in_push && in_full && !in_pop) || (out_push && out_full && !out_pop);
  assign intr_next = inte && (mode == MODE_STROBED) && ((dir == DIR_IN) ? !in_empty : !out_full);

  ppi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_in_fifo (
    .clk(CLK), .reset(RESET), .flush(ctrl_wr), .push(in_push), .pop(in_pop),
    .din(PORT_IN), .dout(in_head), .full(in_full), .empty(in_empty), .count(in_cnt)
  );

  ppi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_out_fifo (
    .clk(CLK), .reset(RESET), .flush(ctrl_wr), .push(out_push), .pop(out_pop),
    .din(DIN), .dout(out_head), .full(out_full), .empty(out_empty), .count(out_cnt)
  );

  assign sel_cnt   = (dir == DIR_IN) ? in_cnt   : out_cnt;
  assign sel_full  = (dir == DIR_IN) ? in_full  : out_full;
  assign sel_empty = (dir == DIR_IN) ? in_empty : out_empty;
  assign stat      = {5'(sel_cnt), ovf, sel_full, sel_empty, INTR};

  assign PORT_OE  = (dir == DIR_OUT);
  assign PORT_OUT = (dir == DIR_IN)       ? '0    :
                    (mode == MODE_BASIC)  ? latch :
                    out_empty             ? '0    : out_head;
  assign IBF      = in_full;
  assign OBF_N    = out_empty;

  always_comb begin
    rdata = '0;
    case (ADDR)
      ADDR_DATA: begin
        if (dir == DIR_OUT)         rdata = PORT_OUT;
        else if (mode == MODE_BASIC) rdata = PORT_IN;
        else if (!in_empty)         rdata = in_head;
      end
      ADDR_CTRL: rdata = WIDTH'(ctrl);
      ADDR_STAT: rdata = WIDTH'(stat);
      default:   rdata = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl     <= CTRL_RESET;
      DOUT     <= '0;
      latch    <= '0;
      ovf      <= 1'b0;
      INTR     <= 1'b0;
      stb_sync <= '1;
      ack_sync <= '1;
    end else begin
      stb_sync <= {stb_sync[1:0], STB_N};
      ack_sync <= {ack_sync[1:0], ACK_N};
      INTR     <= intr_next;
      if (rd_cyc) DOUT <= rdata;
      if (ctrl_wr) ctrl <= {DIN[CTRL_INTE], DIN[CTRL_DIR], DIN[CTRL_MODE]};
      if (data_wr && mode == MODE_BASIC && dir == DIR_OUT) latch <= DIN;
      // a fresh overflow wins over the clear-on-read of the same cycle
      if (ctrl_wr)      ovf <= 1'b0;
      else if (ovf_set) ovf <= 1'b1;
      else if (stat_rd) ovf <= 1'b0;
    end
  end

endmodule
